// File: rtl/udp_axis_slave.sv
// Packetizes an 8-bit AXI-Stream byte stream into UDP datagrams: bytes are buffered,
// then a UDP header is issued and the buffered payload is streamed out behind it.
module udp_axis_slave #(
    parameter int UDP_PORT      = 1230,
    parameter int MAX_PAYLOAD   = 1024,
    parameter int FLUSH_TIMEOUT = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        srst,
    input  logic [31:0] local_ip,
    input  logic [31:0] dest_ip,
    input  logic [15:0] dest_port,
    input  logic [7:0]  in_axis_tdata,
    input  logic        in_axis_tvalid,
    output logic        in_axis_tready,
    input  logic        in_axis_tlast,
    output logic        udp_tx_hdr_valid,
    input  logic        udp_tx_hdr_ready,
    output logic [5:0]  udp_tx_hdr_ip_dscp,
    output logic [1:0]  udp_tx_hdr_ip_ecn,
    output logic [7:0]  udp_tx_hdr_ip_ttl,
    output logic [31:0] udp_tx_hdr_ip_source_ip,
    output logic [31:0] udp_tx_hdr_ip_dest_ip,
    output logic [15:0] udp_tx_hdr_source_port,
    output logic [15:0] udp_tx_hdr_dest_port,
    output logic [15:0] udp_tx_hdr_length,
    output logic [15:0] udp_tx_hdr_checksum,
    output logic [7:0]  udp_tx_payload_tdata,
    output logic        udp_tx_payload_tvalid,
    input  logic        udp_tx_payload_tready,
    output logic        udp_tx_payload_tlast,
    output logic        udp_tx_payload_tuser,
    output logic        busy
);

    localparam int AW = $clog2(MAX_PAYLOAD);
    localparam int CW = AW + 1;
    localparam int IW = (FLUSH_TIMEOUT > 1) ? $clog2(FLUSH_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(MAX_PAYLOAD - 1);
    localparam logic [AW-1:0] ADDR_ZERO = {AW{1'b0}};
    localparam logic [IW-1:0] IDLE_ZERO = {IW{1'b0}};
    localparam logic [IW-1:0] IDLE_LAST = IW'((FLUSH_TIMEOUT > 0) ? (FLUSH_TIMEOUT - 1) : 0);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FILL    = 2'd1,
        ST_HDR     = 2'd2,
        ST_PAYLOAD = 2'd3
    } state_t;

    state_t        state_r, state_next_s;
    logic [CW-1:0] count_r, count_next_s;
    logic [CW-1:0] rd_addr_r;
    logic          in_ready_r;
    logic          hdr_valid_r;
    logic [31:0]   hdr_src_ip_r, hdr_dst_ip_r;
    logic [15:0]   hdr_dst_port_r, hdr_length_r;
    logic [7:0]    pay_tdata_r;
    logic          pay_tvalid_r, pay_tlast_r;
    logic          busy_r;
    logic          accept_s, timeout_s, load_s, hdr_load_s;
    logic [AW-1:0] wr_addr_s;
    logic [7:0]    mem [0:MAX_PAYLOAD-1];

    assign accept_s   = in_ready_r & in_axis_tvalid;
    assign wr_addr_s  = (state_r == ST_IDLE) ? ADDR_ZERO : count_r[AW-1:0];
    assign hdr_load_s = (state_r != ST_HDR) && (state_next_s == ST_HDR);
    // The output register is refilled whenever it is empty or being consumed, so reads never bubble.
    assign load_s     = (state_r == ST_PAYLOAD) && (rd_addr_r != count_r) &&
                        (!pay_tvalid_r || udp_tx_payload_tready);

    generate
        if (FLUSH_TIMEOUT > 0) begin : g_flush
            logic [IW-1:0] idle_cnt_r;

            // Counts consecutive FILL cycles without an accepted beat.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    idle_cnt_r <= IDLE_ZERO;
                end else if (srst) begin
                    idle_cnt_r <= IDLE_ZERO;
                end else if ((state_r == ST_FILL) && !accept_s) begin
                    idle_cnt_r <= idle_cnt_r + IW'(1);
                end else begin
                    idle_cnt_r <= IDLE_ZERO;
                end
            end

            assign timeout_s = (state_r == ST_FILL) && !accept_s && (idle_cnt_r == IDLE_LAST);
        end else begin : g_no_flush
            assign timeout_s = 1'b0;
        end
    endgenerate

    // Next-state and fill-count logic.
    always_comb begin
        state_next_s = state_r;
        count_next_s = count_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    count_next_s = CNT_ONE;
                    state_next_s = in_axis_tlast ? ST_HDR : ST_FILL;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (accept_s) begin
                    count_next_s = count_r + CNT_ONE;
                    if (in_axis_tlast || (count_r == CNT_LAST)) begin
                        state_next_s = ST_HDR;
                    end else begin
                        state_next_s = ST_FILL;
                    end
                end else if (timeout_s) begin
                    state_next_s = ST_HDR;
                end else begin
                    state_next_s = ST_FILL;
                end
            end
            ST_HDR: begin
                if (hdr_valid_r && udp_tx_hdr_ready) begin
                    state_next_s = ST_PAYLOAD;
                end else begin
                    state_next_s = ST_HDR;
                end
            end
            ST_PAYLOAD: begin
                if (pay_tvalid_r && udp_tx_payload_tready && pay_tlast_r) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_PAYLOAD;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                count_next_s = CNT_ZERO;
            end
        endcase
    end

    // Payload buffer write port (no reset so it maps onto block RAM).
    always_ff @(posedge clk) begin
        if (accept_s) begin
            mem[wr_addr_s] <= in_axis_tdata;
        end
    end

    // Payload buffer read port doubling as the output data register.
    always_ff @(posedge clk) begin
        if (load_s) begin
            pay_tdata_r <= mem[rd_addr_r[AW-1:0]];
        end
    end

    // Control state, header fields and output handshake registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r        <= ST_IDLE;
            count_r        <= CNT_ZERO;
            rd_addr_r      <= CNT_ZERO;
            in_ready_r     <= 1'b0;
            hdr_valid_r    <= 1'b0;
            hdr_src_ip_r   <= 32'd0;
            hdr_dst_ip_r   <= 32'd0;
            hdr_dst_port_r <= 16'd0;
            hdr_length_r   <= 16'd0;
            pay_tvalid_r   <= 1'b0;
            pay_tlast_r    <= 1'b0;
            busy_r         <= 1'b0;
        end else if (srst) begin
            state_r        <= ST_IDLE;
            count_r        <= CNT_ZERO;
            rd_addr_r      <= CNT_ZERO;
            in_ready_r     <= 1'b0;
            hdr_valid_r    <= 1'b0;
            hdr_src_ip_r   <= 32'd0;
            hdr_dst_ip_r   <= 32'd0;
            hdr_dst_port_r <= 16'd0;
            hdr_length_r   <= 16'd0;
            pay_tvalid_r   <= 1'b0;
            pay_tlast_r    <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            count_r     <= count_next_s;
            in_ready_r  <= (state_next_s == ST_IDLE) || (state_next_s == ST_FILL);
            hdr_valid_r <= (state_next_s == ST_HDR);
            busy_r      <= (state_next_s != ST_IDLE);
            if (hdr_load_s) begin
                hdr_src_ip_r   <= local_ip;
                hdr_dst_ip_r   <= dest_ip;
                hdr_dst_port_r <= dest_port;
                hdr_length_r   <= 16'(count_next_s) + 16'd8;
            end
            if (state_r == ST_HDR) begin
                rd_addr_r <= CNT_ZERO;
            end else if (load_s) begin
                rd_addr_r <= rd_addr_r + CNT_ONE;
            end
            if (load_s) begin
                pay_tvalid_r <= 1'b1;
                pay_tlast_r  <= (rd_addr_r == (count_r - CNT_ONE));
            end else if (udp_tx_payload_tready) begin
                pay_tvalid_r <= 1'b0;
                pay_tlast_r  <= 1'b0;
            end
        end
    end

    assign in_axis_tready          = in_ready_r;
    assign udp_tx_hdr_valid        = hdr_valid_r;
    assign udp_tx_hdr_ip_dscp      = 6'd0;
    assign udp_tx_hdr_ip_ecn       = 2'd0;
    assign udp_tx_hdr_ip_ttl       = 8'd64;
    assign udp_tx_hdr_ip_source_ip = hdr_src_ip_r;
    assign udp_tx_hdr_ip_dest_ip   = hdr_dst_ip_r;
    assign udp_tx_hdr_source_port  = 16'(UDP_PORT);
    assign udp_tx_hdr_dest_port    = hdr_dst_port_r;
    assign udp_tx_hdr_length       = hdr_length_r;
    assign udp_tx_hdr_checksum     = 16'd0;
    assign udp_tx_payload_tdata    = pay_tdata_r;
    assign udp_tx_payload_tvalid   = pay_tvalid_r;
    assign udp_tx_payload_tlast    = pay_tlast_r;
    assign udp_tx_payload_tuser    = 1'b0;
    assign busy                    = busy_r;

endmodule

// File: tb/tb_udp_axis_slave.sv
// Scoreboard bench for udp_axis_slave: stimulus pushes expected headers/bytes,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_udp_axis_slave;

    localparam int MAXP = 16;
    localparam int TOUT = 10;
    localparam logic [31:0] LOCAL_IP = 32'h0A00_0001;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        srst = 1'b0;
    logic [31:0] local_ip = LOCAL_IP;
    logic [31:0] dest_ip = 32'hC0A8_0102;
    logic [15:0] dest_port = 16'd5000;
    logic [7:0]  in_tdata = 8'd0;
    logic        in_tvalid = 1'b0;
    logic        in_tready;
    logic        in_tlast = 1'b0;
    logic        hdr_valid;
    logic        hdr_ready = 1'b1;
    logic [5:0]  hdr_dscp;
    logic [1:0]  hdr_ecn;
    logic [7:0]  hdr_ttl;
    logic [31:0] hdr_src_ip, hdr_dst_ip;
    logic [15:0] hdr_sport, hdr_dport, hdr_len, hdr_csum;
    logic [7:0]  pay_tdata;
    logic        pay_tvalid;
    logic        pay_tready = 1'b1;
    logic        pay_tlast, pay_tuser;
    logic        busy;

    udp_axis_slave #(.UDP_PORT(1230), .MAX_PAYLOAD(MAXP), .FLUSH_TIMEOUT(TOUT)) dut (
        .clk(clk), .reset(reset), .srst(srst),
        .local_ip(local_ip), .dest_ip(dest_ip), .dest_port(dest_port),
        .in_axis_tdata(in_tdata), .in_axis_tvalid(in_tvalid),
        .in_axis_tready(in_tready), .in_axis_tlast(in_tlast),
        .udp_tx_hdr_valid(hdr_valid), .udp_tx_hdr_ready(hdr_ready),
        .udp_tx_hdr_ip_dscp(hdr_dscp), .udp_tx_hdr_ip_ecn(hdr_ecn),
        .udp_tx_hdr_ip_ttl(hdr_ttl), .udp_tx_hdr_ip_source_ip(hdr_src_ip),
        .udp_tx_hdr_ip_dest_ip(hdr_dst_ip), .udp_tx_hdr_source_port(hdr_sport),
        .udp_tx_hdr_dest_port(hdr_dport), .udp_tx_hdr_length(hdr_len),
        .udp_tx_hdr_checksum(hdr_csum),
        .udp_tx_payload_tdata(pay_tdata), .udp_tx_payload_tvalid(pay_tvalid),
        .udp_tx_payload_tready(pay_tready), .udp_tx_payload_tlast(pay_tlast),
        .udp_tx_payload_tuser(pay_tuser), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [8:0]  exp_pay[$];
    logic [63:0] exp_hdr[$];
    logic [7:0]  cur[$];

    bit hdr_low = 1'b0, hdr_rand = 1'b0, pay_rand = 1'b0;
    bit pay_open = 1'b0, hdr_hold = 1'b0, pay_hold = 1'b0, prev_nonlast = 1'b0;
    logic [143:0] hdr_saved;
    logic [8:0]   pay_saved;
    int pay_beats = 0;
    int acc_cyc = 0;

    function automatic void chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endfunction

    function automatic void flush_model();
        int n;
        n = cur.size();
        exp_hdr.push_back({dest_ip, dest_port, 16'(n + 8)});
        for (int i = 0; i < n; i++) exp_pay.push_back({(i == n - 1), cur[i]});
        cur.delete();
    endfunction

    // Sink-side ready generation.
    always @(posedge clk) begin
        #1;
        hdr_ready  = hdr_low ? 1'b0 : (hdr_rand ? 1'($urandom_range(0, 1)) : 1'b1);
        pay_tready = pay_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: compares every header/payload transfer against the scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            logic [63:0]  eh;
            logic [8:0]   ep;
            logic [143:0] hcur;
            hcur = {hdr_dscp, hdr_ecn, hdr_ttl, hdr_src_ip, hdr_dst_ip, hdr_sport, hdr_dport, hdr_len, hdr_csum};
            if (in_tvalid && (hdr_valid || pay_tvalid)) chk("in_tready_blocked", in_tready, 1'b0);
            if (hdr_hold) begin
                chk("hdr_valid_held", hdr_valid, 1'b1);
                chk("hdr_stable", hcur, hdr_saved);
            end
            if (hdr_valid) begin
                if (hdr_ready) begin
                    if (exp_hdr.size() == 0) begin
                        chk("hdr_unexpected", hdr_valid, 1'b0);
                    end else begin
                        eh = exp_hdr.pop_front();
                        chk("hdr_fields", hcur, {6'd0, 2'd0, 8'd64, LOCAL_IP, eh[63:32], 16'd1230, eh[31:16], eh[15:0], 16'd0});
                    end
                    pay_open = 1'b1;
                    hdr_hold = 1'b0;
                end else begin
                    hdr_hold  = 1'b1;
                    hdr_saved = hcur;
                end
            end else begin
                hdr_hold = 1'b0;
            end
            if (pay_hold || prev_nonlast) chk("pay_valid_cont", pay_tvalid, 1'b1);
            if (pay_hold && pay_tvalid) chk("pay_stable", {pay_tlast, pay_tdata}, pay_saved);
            if (pay_tvalid) begin
                chk("pay_after_hdr", pay_open, 1'b1);
                if (pay_tready) begin
                    if (exp_pay.size() == 0) begin
                        chk("pay_unexpected", pay_tvalid, 1'b0);
                    end else begin
                        ep = exp_pay.pop_front();
                        chk("pay_beat", {pay_tuser, pay_tlast, pay_tdata}, {1'b0, ep});
                    end
                    pay_beats++;
                    if (pay_tlast) pay_open = 1'b0;
                    prev_nonlast = !pay_tlast;
                    pay_hold     = 1'b0;
                end else begin
                    pay_hold     = 1'b1;
                    pay_saved    = {pay_tlast, pay_tdata};
                    prev_nonlast = 1'b0;
                end
            end else begin
                pay_hold     = 1'b0;
                prev_nonlast = 1'b0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] d, input bit last, input int gap);
        int n;
        in_tvalid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_tdata  = d;
        in_tlast  = last;
        in_tvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_tready && n < 2000) begin
            n++;
            @(negedge clk);
        end
        if (n >= 2000) chk("in_accept_timeout", in_tready, 1'b1);
        acc_cyc = cyc + 1;
        cur.push_back(d);
        if (last || cur.size() == MAXP) flush_model();
        @(posedge clk);
        #1;
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while ((exp_pay.size() != 0 || exp_hdr.size() != 0 || busy) && n < 5000) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(nm, (n < 5000), 1'b1);
    endtask

    task automatic wait_hdr_valid();
        int n;
        n = 0;
        while (!hdr_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("hdr_appears", hdr_valid, 1'b1);
    endtask

    initial begin
        int len;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {in_tready, hdr_valid, pay_tvalid, pay_tlast, busy}, 5'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_reset", in_tready, 1'b1);

        // Five-byte frame, sinks always ready.
        for (int i = 1; i <= 5; i++) send_byte(8'(i), (i == 5), 0);
        wait_done("drain_basic");

        // Twenty bytes split into 16 + 4.
        for (int i = 0; i < 20; i++) send_byte(8'(i), (i == 19), 0);
        wait_done("drain_split");

        // Partial frame flushed by idle timeout.
        for (int i = 0; i < 3; i++) send_byte(8'hA1 + 8'(i), 1'b0, 0);
        flush_model();
        wait_hdr_valid();
        chk("flush_latency", 32'(cyc - acc_cyc), 32'(TOUT));
        wait_done("drain_timeout");

        // Header stalled 20 cycles, then random payload back-pressure.
        hdr_low = 1'b1;
        for (int i = 0; i < 6; i++) send_byte(8'h30 + 8'(i), (i == 5), 0);
        wait_hdr_valid();
        repeat (20) @(posedge clk);
        hdr_low  = 1'b1;
        #2;
        hdr_low  = 1'b0;
        pay_rand = 1'b1;
        wait_done("drain_stall");
        pay_rand = 1'b0;

        // Reset in the middle of the payload after byte 2 of 8.
        pay_beats = 0;
        for (int i = 0; i < 8; i++) send_byte(8'h60 + 8'(i), (i == 7), 0);
        len = 0;
        while (pay_beats < 2 && len < 500) begin
            @(posedge clk);
            len++;
        end
        #2;
        reset = 1'b0;
        #1;
        chk("mid_reset_outputs", {pay_tvalid, busy, hdr_valid, in_tready}, 4'd0);
        exp_pay.delete();
        exp_hdr.delete();
        cur.delete();
        pay_open = 1'b0; hdr_hold = 1'b0; pay_hold = 1'b0; prev_nonlast = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_mid_reset", in_tready, 1'b1);
        send_byte(8'h5A, 1'b1, 0);
        wait_done("drain_one_byte");

        // 100 random back-to-back frames with random gaps and sink readiness.
        dest_port = 16'h2222;
        dest_ip   = 32'hC0A8_0A0B;
        hdr_rand  = 1'b1;
        pay_rand  = 1'b1;
        for (int f = 0; f < 100; f++) begin
            len = $urandom_range(1, 40);
            for (int i = 0; i < len; i++)
                send_byte(8'($urandom), (i == len - 1), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
        end
        wait_done("drain_random");
        hdr_rand = 1'b0;
        pay_rand = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

endmodule
